// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-requester I2C command arbiter.
package i2c_arb_pkg;

  // Arbiter FSM states; also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT0     = 3'd1,
    ST_GRANT1     = 3'd2,
    ST_FORCE_STOP = 3'd3,
    ST_DRAIN      = 3'd4
  } arb_state_t;

  // Bit positions inside cmd_flags = {start, read, write, write_multiple, stop}.
  localparam int FLAG_START          = 4;
  localparam int FLAG_READ           = 3;
  localparam int FLAG_WRITE          = 2;
  localparam int FLAG_WRITE_MULTIPLE = 1;
  localparam int FLAG_STOP           = 0;

  // Command the arbiter issues on its own to close an abandoned transaction.
  localparam logic [4:0] FLAGS_STOP_ONLY = 5'b00001;

  // Requester index: 0 = UART command block, 1 = sensor poller.
  typedef logic req_id_t;

endpackage

// File: rtl/i2c_arb_port_mux.sv
// Routes the command, write and read paths between the master and one owner.
// Valid/ready: a transfer happens in a cycle where valid and ready are both 1;
// valid never depends on ready. Disabled paths present valid=0 and ready=0.
module i2c_arb_port_mux
  import i2c_arb_pkg::*;
(
  input  req_id_t    sel,
  input  logic       cmd_en,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic [6:0] req0_cmd_address,
  input  logic [4:0] req0_cmd_flags,
  input  logic       req0_cmd_valid,
  output logic       req0_cmd_ready,
  input  logic [6:0] req1_cmd_address,
  input  logic [4:0] req1_cmd_flags,
  input  logic       req1_cmd_valid,
  output logic       req1_cmd_ready,
  input  logic [7:0] req0_wr_tdata,
  input  logic       req0_wr_tvalid,
  output logic       req0_wr_tready,
  input  logic       req0_wr_tlast,
  input  logic [7:0] req1_wr_tdata,
  input  logic       req1_wr_tvalid,
  output logic       req1_wr_tready,
  input  logic       req1_wr_tlast,
  output logic [7:0] req0_rd_tdata,
  output logic       req0_rd_tvalid,
  input  logic       req0_rd_tready,
  output logic       req0_rd_tlast,
  output logic [7:0] req1_rd_tdata,
  output logic       req1_rd_tvalid,
  input  logic       req1_rd_tready,
  output logic       req1_rd_tlast,
  output logic [6:0] mst_cmd_address,
  output logic [4:0] mst_cmd_flags,
  output logic       mst_cmd_valid,
  input  logic       mst_cmd_ready,
  output logic [7:0] mst_wr_tdata,
  output logic       mst_wr_tvalid,
  input  logic       mst_wr_tready,
  output logic       mst_wr_tlast,
  input  logic [7:0] mst_rd_tdata,
  input  logic       mst_rd_tvalid,
  output logic       mst_rd_tready,
  input  logic       mst_rd_tlast
);

  // Command path: owner's command forward, master ready back to the owner only.
  always_comb begin
    mst_cmd_address = '0;
    mst_cmd_flags   = '0;
    mst_cmd_valid   = 1'b0;
    req0_cmd_ready  = 1'b0;
    req1_cmd_ready  = 1'b0;
    if (cmd_en) begin
      if (sel) begin
        mst_cmd_address = req1_cmd_address;
        mst_cmd_flags   = req1_cmd_flags;
        mst_cmd_valid   = req1_cmd_valid;
        req1_cmd_ready  = mst_cmd_ready;
      end else begin
        mst_cmd_address = req0_cmd_address;
        mst_cmd_flags   = req0_cmd_flags;
        mst_cmd_valid   = req0_cmd_valid;
        req0_cmd_ready  = mst_cmd_ready;
      end
    end
  end

  // Write stream: owner's bytes forward, master tready back to the owner only.
  always_comb begin
    mst_wr_tdata   = '0;
    mst_wr_tvalid  = 1'b0;
    mst_wr_tlast   = 1'b0;
    req0_wr_tready = 1'b0;
    req1_wr_tready = 1'b0;
    if (wr_en) begin
      if (sel) begin
        mst_wr_tdata   = req1_wr_tdata;
        mst_wr_tvalid  = req1_wr_tvalid;
        mst_wr_tlast   = req1_wr_tlast;
        req1_wr_tready = mst_wr_tready;
      end else begin
        mst_wr_tdata   = req0_wr_tdata;
        mst_wr_tvalid  = req0_wr_tvalid;
        mst_wr_tlast   = req0_wr_tlast;
        req0_wr_tready = mst_wr_tready;
      end
    end
  end

  // Read stream: data/last fan out to both, only the owner sees tvalid.
  always_comb begin
    req0_rd_tdata  = mst_rd_tdata;
    req1_rd_tdata  = mst_rd_tdata;
    req0_rd_tlast  = mst_rd_tlast;
    req1_rd_tlast  = mst_rd_tlast;
    req0_rd_tvalid = 1'b0;
    req1_rd_tvalid = 1'b0;
    mst_rd_tready  = 1'b0;
    if (rd_en) begin
      if (sel) begin
        req1_rd_tvalid = mst_rd_tvalid;
        mst_rd_tready  = req1_rd_tready;
      end else begin
        req0_rd_tvalid = mst_rd_tvalid;
        mst_rd_tready  = req0_rd_tready;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Grants the single i2c_master to one of two requesters per I2C transaction,
// round-robin on ties, with an idle timeout that forces a stop.
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] req0_cmd_address,
  input  logic [4:0] req0_cmd_flags,
  input  logic       req0_cmd_valid,
  output logic       req0_cmd_ready,
  input  logic [7:0] req0_wr_tdata,
  input  logic       req0_wr_tvalid,
  output logic       req0_wr_tready,
  input  logic       req0_wr_tlast,
  output logic [7:0] req0_rd_tdata,
  output logic       req0_rd_tvalid,
  input  logic       req0_rd_tready,
  output logic       req0_rd_tlast,
  output logic       req0_grant,
  output logic       req0_missed_ack,
  output logic       req0_timeout,
  input  logic [6:0] req1_cmd_address,
  input  logic [4:0] req1_cmd_flags,
  input  logic       req1_cmd_valid,
  output logic       req1_cmd_ready,
  input  logic [7:0] req1_wr_tdata,
  input  logic       req1_wr_tvalid,
  output logic       req1_wr_tready,
  input  logic       req1_wr_tlast,
  output logic [7:0] req1_rd_tdata,
  output logic       req1_rd_tvalid,
  input  logic       req1_rd_tready,
  output logic       req1_rd_tlast,
  output logic       req1_grant,
  output logic       req1_missed_ack,
  output logic       req1_timeout,
  output logic [6:0] mst_cmd_address,
  output logic [4:0] mst_cmd_flags,
  output logic       mst_cmd_valid,
  input  logic       mst_cmd_ready,
  output logic [7:0] mst_wr_tdata,
  output logic       mst_wr_tvalid,
  input  logic       mst_wr_tready,
  output logic       mst_wr_tlast,
  input  logic [7:0] mst_rd_tdata,
  input  logic       mst_rd_tvalid,
  output logic       mst_rd_tready,
  input  logic       mst_rd_tlast,
  input  logic       mst_busy,
  input  logic       mst_missed_ack,
  output arb_state_t dbg_state
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  arb_state_t  state_q, state_d;
  req_id_t     owner_q, owner_d;
  req_id_t     last_grant_q, last_grant_d;
  logic [15:0] idle_cnt_q;
  logic [1:0]  drain_cnt_q;

  logic       in_grant, in_force_stop, active;
  logic       cmd_en, rd_en;
  logic [6:0] mux_cmd_address;
  logic [4:0] mux_cmd_flags;
  logic       mux_cmd_valid;
  logic       owner_cmd_hs, owner_wr_hs, stop_hs, expired, timeout_fire;

  // Pass-through is gated by rstn as well so a reset blocks it the same cycle.
  assign in_grant      = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
  assign in_force_stop = (state_q == ST_FORCE_STOP);
  assign active        = rstn && (state_q != ST_IDLE);
  assign cmd_en        = rstn && in_grant;
  assign rd_en         = active;

  i2c_arb_port_mux u_port_mux (
    .sel              (owner_q),
    .cmd_en           (cmd_en),
    .wr_en            (cmd_en),
    .rd_en            (rd_en),
    .req0_cmd_address (req0_cmd_address),
    .req0_cmd_flags   (req0_cmd_flags),
    .req0_cmd_valid   (req0_cmd_valid),
    .req0_cmd_ready   (req0_cmd_ready),
    .req1_cmd_address (req1_cmd_address),
    .req1_cmd_flags   (req1_cmd_flags),
    .req1_cmd_valid   (req1_cmd_valid),
    .req1_cmd_ready   (req1_cmd_ready),
    .req0_wr_tdata    (req0_wr_tdata),
    .req0_wr_tvalid   (req0_wr_tvalid),
    .req0_wr_tready   (req0_wr_tready),
    .req0_wr_tlast    (req0_wr_tlast),
    .req1_wr_tdata    (req1_wr_tdata),
    .req1_wr_tvalid   (req1_wr_tvalid),
    .req1_wr_tready   (req1_wr_tready),
    .req1_wr_tlast    (req1_wr_tlast),
    .req0_rd_tdata    (req0_rd_tdata),
    .req0_rd_tvalid   (req0_rd_tvalid),
    .req0_rd_tready   (req0_rd_tready),
    .req0_rd_tlast    (req0_rd_tlast),
    .req1_rd_tdata    (req1_rd_tdata),
    .req1_rd_tvalid   (req1_rd_tvalid),
    .req1_rd_tready   (req1_rd_tready),
    .req1_rd_tlast    (req1_rd_tlast),
    .mst_cmd_address  (mux_cmd_address),
    .mst_cmd_flags    (mux_cmd_flags),
    .mst_cmd_valid    (mux_cmd_valid),
    .mst_cmd_ready    (mst_cmd_ready),
    .mst_wr_tdata     (mst_wr_tdata),
    .mst_wr_tvalid    (mst_wr_tvalid),
    .mst_wr_tready    (mst_wr_tready),
    .mst_wr_tlast     (mst_wr_tlast),
    .mst_rd_tdata     (mst_rd_tdata),
    .mst_rd_tvalid    (mst_rd_tvalid),
    .mst_rd_tready    (mst_rd_tready),
    .mst_rd_tlast     (mst_rd_tlast)
  );

  // Master command port: arbiter-generated stop in FORCE_STOP, owner otherwise.
  always_comb begin
    mst_cmd_address = mux_cmd_address;
    mst_cmd_flags   = mux_cmd_flags;
    mst_cmd_valid   = mux_cmd_valid;
    if (rstn && in_force_stop) begin
      mst_cmd_address = '0;
      mst_cmd_flags   = FLAGS_STOP_ONLY;
      mst_cmd_valid   = 1'b1;
    end
  end

  // A stop handshake in the expiry cycle wins: no timeout pulse in that case.
  assign owner_cmd_hs = in_grant && mux_cmd_valid && mst_cmd_ready;
  assign owner_wr_hs  = mst_wr_tvalid && mst_wr_tready;
  assign stop_hs      = owner_cmd_hs && mux_cmd_flags[FLAG_STOP];
  assign expired      = in_grant && (idle_cnt_q >= TIMEOUT_LIMIT);
  assign timeout_fire = rstn && expired && !stop_hs;

  // Status outputs follow the current owner while the bus is held.
  assign req0_grant      = active && !owner_q;
  assign req1_grant      = active && owner_q;
  assign req0_missed_ack = mst_missed_ack && req0_grant;
  assign req1_missed_ack = mst_missed_ack && req1_grant;
  assign req0_timeout    = timeout_fire && !owner_q;
  assign req1_timeout    = timeout_fire && owner_q;
  assign dbg_state       = state_q;

  // Next-state: tie-break against last_grant, release only after a quiet drain.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_cmd_valid || req1_cmd_valid) begin
          if (req0_cmd_valid && req1_cmd_valid) owner_d = !last_grant_q;
          else                                  owner_d = req1_cmd_valid;
          last_grant_d = owner_d;
          state_d      = owner_d ? ST_GRANT1 : ST_GRANT0;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (stop_hs)      state_d = ST_DRAIN;
        else if (expired) state_d = ST_FORCE_STOP;
      end
      ST_FORCE_STOP: begin
        if (mst_cmd_ready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((drain_cnt_q != 2'd0) && !mst_busy && !mst_rd_tvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Owner-idle counter: restarts on any owner activity or while the master works.
  always_ff @(posedge clk) begin
    if (!rstn || !in_grant || owner_cmd_hs || owner_wr_hs || mst_busy) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != 16'hFFFF) begin
      idle_cnt_q <= idle_cnt_q + 16'd1;
    end
  end

  // Cycles spent in DRAIN, saturating; enforces the minimum drain length.
  always_ff @(posedge clk) begin
    if (!rstn || (state_q != ST_DRAIN)) begin
      drain_cnt_q <= '0;
    end else if (drain_cnt_q != 2'd3) begin
      drain_cnt_q <= drain_cnt_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed + randomized bench for i2c_cmd_arbiter with a transaction-level model.
module tb_i2c_cmd_arbiter;
  import i2c_arb_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] c_addr  [2];
  logic [4:0] c_flags [2];
  logic [1:0] c_valid;
  wire  [1:0] c_ready;
  logic [7:0] w_data  [2];
  logic [1:0] w_valid, w_last;
  wire  [1:0] w_ready;
  wire  [7:0] r_data  [2];
  wire  [1:0] r_valid, r_last;
  logic [1:0] r_ready;
  wire  [1:0] grant, missed, tmo;
  wire  [6:0] m_addr;
  wire  [4:0] m_flags;
  wire        m_valid;
  logic       m_ready;
  wire  [7:0] m_wdata;
  wire        m_wvalid, m_wlast;
  logic       m_wready;
  logic [7:0] m_rdata;
  logic       m_rvalid, m_rlast;
  wire        m_rready;
  logic       m_busy, m_miss;
  arb_state_t dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int lg = 1;  // model: last granted requester

  // Clock
  always #5 clk = ~clk;

  i2c_cmd_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req0_cmd_address(c_addr[0]), .req0_cmd_flags(c_flags[0]), .req0_cmd_valid(c_valid[0]),
    .req0_cmd_ready(c_ready[0]),
    .req0_wr_tdata(w_data[0]), .req0_wr_tvalid(w_valid[0]), .req0_wr_tready(w_ready[0]),
    .req0_wr_tlast(w_last[0]),
    .req0_rd_tdata(r_data[0]), .req0_rd_tvalid(r_valid[0]), .req0_rd_tready(r_ready[0]),
    .req0_rd_tlast(r_last[0]),
    .req0_grant(grant[0]), .req0_missed_ack(missed[0]), .req0_timeout(tmo[0]),
    .req1_cmd_address(c_addr[1]), .req1_cmd_flags(c_flags[1]), .req1_cmd_valid(c_valid[1]),
    .req1_cmd_ready(c_ready[1]),
    .req1_wr_tdata(w_data[1]), .req1_wr_tvalid(w_valid[1]), .req1_wr_tready(w_ready[1]),
    .req1_wr_tlast(w_last[1]),
    .req1_rd_tdata(r_data[1]), .req1_rd_tvalid(r_valid[1]), .req1_rd_tready(r_ready[1]),
    .req1_rd_tlast(r_last[1]),
    .req1_grant(grant[1]), .req1_missed_ack(missed[1]), .req1_timeout(tmo[1]),
    .mst_cmd_address(m_addr), .mst_cmd_flags(m_flags), .mst_cmd_valid(m_valid),
    .mst_cmd_ready(m_ready),
    .mst_wr_tdata(m_wdata), .mst_wr_tvalid(m_wvalid), .mst_wr_tready(m_wready),
    .mst_wr_tlast(m_wlast),
    .mst_rd_tdata(m_rdata), .mst_rd_tvalid(m_rvalid), .mst_rd_tready(m_rready),
    .mst_rd_tlast(m_rlast),
    .mst_busy(m_busy), .mst_missed_ack(m_miss),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    c_valid = '0; w_valid = '0; w_last = '0; r_ready = '0;
    m_ready = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rdata = '0; m_busy = 1'b0; m_miss = 1'b0;
    for (int r = 0; r < 2; r++) begin
      c_addr[r] = '0; c_flags[r] = '0; w_data[r] = '0;
    end
  endtask

  task automatic apply_reset;
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    lg = 1;
    tick();
  endtask

  // Model: single pending requester wins; on a tie the one not granted last.
  function automatic int pick(input logic p0, input logic p1);
    if (p0 && p1) return 1 - lg;
    if (p0) return 0;
    return 1;
  endfunction

  // Called in an IDLE cycle with requests set up; returns the granted owner.
  task automatic arbitrate(input string tag, output int owner);
    owner = pick(c_valid[0], c_valid[1]);
    lg = owner;
    #1;
    chk({tag, "_idle_grant"}, grant, 2'b00);
    chk({tag, "_idle_mvalid"}, m_valid, 1'b0);
    tick();
    #1;
    chk({tag, "_grant"}, grant, (owner == 0) ? 2'b01 : 2'b10);
  endtask

  // Runs ncmd commands for the owner (last has stop), then checks the release.
  task automatic serve(input int who, input int ncmd, input int nbusy, input string tag);
    int oth, d, rel;
    logic rd;
    oth = 1 - who;
    for (int i = 0; i < ncmd; i++) begin
      if (i > 0) c_addr[who] = 7'($urandom);
      rd = 1'($urandom);
      c_flags[who] = '0;
      c_flags[who][FLAG_START] = (i == 0);
      c_flags[who][FLAG_READ]  = rd;
      c_flags[who][FLAG_WRITE] = !rd;
      c_flags[who][FLAG_STOP]  = (i == ncmd - 1);
      c_valid[who] = 1'b1;
      m_ready = 1'b0;
      d = $urandom_range(0, 2);
      for (int j = 0; j < d; j++) begin
        #1;
        chk({tag, "_wait_mvalid"}, m_valid, 1'b1);
        chk({tag, "_wait_addr"}, m_addr, c_addr[who]);
        chk({tag, "_wait_ready"}, c_ready, 2'b00);
        tick();
      end
      m_ready = 1'b1;
      m_wready = 1'b1;
      w_valid = 2'b11;
      w_data[who] = 8'($urandom);
      w_data[oth] = 8'($urandom);
      m_miss = 1'($urandom);
      #1;
      chk({tag, "_addr"}, m_addr, c_addr[who]);
      chk({tag, "_flags"}, m_flags, c_flags[who]);
      chk({tag, "_own_ready"}, c_ready[who], 1'b1);
      chk({tag, "_oth_ready"}, c_ready[oth], 1'b0);
      chk({tag, "_wdata"}, m_wdata, w_data[who]);
      chk({tag, "_wr_ready"}, w_ready, (who == 0) ? 2'b01 : 2'b10);
      chk({tag, "_own_miss"}, missed[who], m_miss);
      chk({tag, "_oth_miss"}, missed[oth], 1'b0);
      tick();
      m_ready = 1'b0; m_wready = 1'b0; w_valid = '0; m_miss = 1'b0;
    end
    c_valid[who] = 1'b0;
    rel = (nbusy + 2 > 3) ? nbusy + 2 : 3;
    for (int c = 1; c <= rel; c++) begin
      m_busy = (c <= nbusy);
      m_rvalid = (c == 1 && nbusy > 0);
      m_rdata = 8'($urandom);
      r_ready[who] = 1'b1;
      #1;
      if (c < rel) begin
        chk({tag, "_drain_grant"}, grant[who], 1'b1);
        if (c == 1) chk({tag, "_drain_mvalid"}, m_valid, 1'b0);
        if (m_rvalid) begin
          chk({tag, "_rd_data"}, r_data[who], m_rdata);
          chk({tag, "_rd_valid"}, r_valid, (who == 0) ? 2'b01 : 2'b10);
          chk({tag, "_rd_ready"}, m_rready, 1'b1);
        end
        tick();
      end else begin
        chk({tag, "_release"}, grant, 2'b00);
      end
    end
    m_busy = 1'b0; m_rvalid = 1'b0; r_ready = '0;
  endtask

  initial begin
    int owner;
    // Reset with every input asserted: nothing may pass through.
    idle_inputs();
    rstn = 1'b0;
    c_valid = 2'b11; w_valid = 2'b11; m_wready = 1'b1; m_rvalid = 1'b1;
    r_ready = 2'b11; m_ready = 1'b1; m_busy = 1'b1;
    tick(); tick();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", tmo, 2'b00);
    chk("rst_cmd_ready", c_ready, 2'b00);
    chk("rst_wr_ready", w_ready, 2'b00);
    chk("rst_rd_valid", r_valid, 2'b00);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mwvalid", m_wvalid, 1'b0);
    chk("rst_mrready", m_rready, 1'b0);
    apply_reset();
    chk("rst_state", dbg_state, ST_IDLE);

    // Contention straight after reset, then round robin over four transactions.
    c_valid = 2'b11;
    c_addr[0] = 7'($urandom); c_addr[1] = 7'($urandom);
    for (int t = 0; t < 4; t++) begin
      arbitrate("rr", owner);
      serve(owner, $urandom_range(1, 3), $urandom_range(0, 3), "rr");
      c_valid[owner] = 1'b1;
      c_addr[owner] = 7'($urandom);
    end
    c_valid = '0;
    tick();

    // Single requester read at 0x34 returning 0xA5.
    c_addr[0] = 7'h34;
    c_flags[0] = 5'b11001;
    c_valid[0] = 1'b1;
    arbitrate("rd", owner);
    #1;
    chk("rd_addr", m_addr, 7'h34);
    chk("rd_mvalid", m_valid, 1'b1);
    m_ready = 1'b1;
    #1;
    chk("rd_cmd_ready", c_ready, 2'b01);
    tick();
    c_valid[0] = 1'b0; m_ready = 1'b0; m_busy = 1'b1;
    m_rdata = 8'hA5; m_rvalid = 1'b1; m_rlast = 1'b1; r_ready[0] = 1'b1;
    #1;
    chk("rd_data", r_data[0], 8'hA5);
    chk("rd_valid", r_valid, 2'b01);
    chk("rd_last", r_last[0], 1'b1);
    chk("rd_mrready", m_rready, 1'b1);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("rd_hold1", grant, 2'b01);
    tick();
    m_busy = 1'b0;
    #1;
    chk("rd_hold2", grant, 2'b01);
    tick();
    #1;
    chk("rd_release", grant, 2'b00);
    r_ready = '0;

    // Timeout: req1 opens a write and stalls; req0 waits behind it.
    c_addr[1] = 7'h50; c_flags[1] = 5'b10100; c_valid[1] = 1'b1;
    arbitrate("to", owner);
    m_ready = 1'b1;
    #1;
    chk("to_cmd_ready", c_ready, 2'b10);
    tick();
    m_ready = 1'b0; c_valid[1] = 1'b0;
    c_addr[0] = 7'h21; c_flags[0] = 5'b10001; c_valid[0] = 1'b1;
    for (int c = 1; c <= TO; c++) begin
      m_miss = (c == 5);
      #1;
      chk("to_no_pulse", tmo, 2'b00);
      chk("to_waiter_ready", c_ready[0], 1'b0);
      if (c == 5) chk("to_missed_route", missed, 2'b10);
      tick();
    end
    m_miss = 1'b0;
    #1;
    chk("to_pulse", tmo, 2'b10);
    tick();
    #1;
    chk("to_pulse_once", tmo, 2'b00);
    chk("fs_mvalid", m_valid, 1'b1);
    chk("fs_flags", m_flags, FLAGS_STOP_ONLY);
    chk("fs_addr", m_addr, 7'h00);
    chk("fs_cmd_ready", c_ready, 2'b00);
    chk("fs_grant", grant, 2'b10);
    tick();
    #1;
    chk("fs_hold", m_flags, FLAGS_STOP_ONLY);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    chk("fs_drain1", grant, 2'b10);
    tick();
    #1;
    chk("fs_drain2", grant, 2'b10);
    tick();
    #1;
    chk("fs_release", grant, 2'b00);
    arbitrate("after_to", owner);
    serve(owner, 1, 0, "after_to");

    // Randomized traffic; a waiting request keeps its address until served.
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!c_valid[r] && $urandom_range(0, 1) == 1) begin
          c_valid[r] = 1'b1;
          c_addr[r] = 7'($urandom);
        end
      end
      if (c_valid == 2'b00) begin
        int r;
        r = $urandom_range(0, 1);
        c_valid[r] = 1'b1;
        c_addr[r] = 7'($urandom);
      end
      arbitrate("rnd", owner);
      serve(owner, $urandom_range(1, 3), $urandom_range(0, 3), "rnd");
    end

    // Reset during a req0 write burst.
    c_valid = '0;
    tick();
    c_valid[0] = 1'b1; c_addr[0] = 7'h11; c_flags[0] = 5'b10100;
    arbitrate("mid", owner);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; c_valid[0] = 1'b0;
    w_valid[0] = 1'b1; w_data[0] = 8'h3C; m_wready = 1'b1;
    #1;
    chk("mid_wvalid", m_wvalid, 1'b1);
    chk("mid_wdata", m_wdata, 8'h3C);
    rstn = 1'b0;
    #1;
    chk("mid_rst_wvalid", m_wvalid, 1'b0);
    chk("mid_rst_grant", grant, 2'b00);
    tick();
    rstn = 1'b1;
    lg = 1;
    #1;
    chk("mid_state", dbg_state, ST_IDLE);
    chk("mid_grant", grant, 2'b00);
    chk("mid_post_wvalid", m_wvalid, 1'b0);
    chk("mid_wr_ready", w_ready, 2'b00);
    chk("mid_mvalid", m_valid, 1'b0);
    tick();
    #1;
    chk("mid_still_blocked", m_wvalid, 1'b0);
    w_valid = '0; m_wready = 1'b0;

    // Tie after reset goes to req0 again.
    c_valid = 2'b11;
    arbitrate("tie", owner);
    serve(owner, 1, 1, "tie");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
